// File: rtl/qea_run_sequencer_pkg.sv
// Shared FSM state type, fixed-point unity constant and row-count helper
// for the QEA run sequencer.
package qea_seq_pkg;

  localparam int NUM_FRAC_BIT = 30;
  localparam logic [31:0] ONE_FP = 32'd1 << NUM_FRAC_BIT;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_CTX,
    S_INIT_ST,
    S_START,
    S_WAIT,
    S_RD_ADDR,
    S_RD_CAP,
    S_RD_OUT,
    S_DONE
  } seq_state_t;

  // STATE RAM rows holding 2^qbit_num amplitudes, PE_NUM per row
  function automatic logic [31:0] rows(input int qbit_num, input int pe_num_width);
    return 32'd1 << (qbit_num - pe_num_width);
  endfunction

endpackage

// File: rtl/qea_run_sequencer_if.sv
// Host-side streams of the run sequencer: CTX word ingest and state-vector readout.
// master = host/DMA, slave = sequencer.
interface qea_run_sequencer_if #(
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int PE_NUM                  = 4,
  parameter int STATE_DATA_WIDTH        = 64
);
  logic                                 ctx_valid;
  logic                                 ctx_ready;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_word;
  logic                                 rd_valid;
  logic                                 rd_ready;
  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   rd_data;
  logic                                 rd_last;

  modport master (
    output ctx_valid, ctx_word, rd_ready,
    input  ctx_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  ctx_valid, ctx_word, rd_ready,
    output ctx_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/qea_run_sequencer.sv
// Host-side run controller for the QEA core: CTX load, STATE init, start/complete, row readout.
// Optional QEA_SEQ_CYCLE_CNT_EN adds o_exec_cycles (WAIT-phase cycle count, saturating).
//
// state     | meaning
// IDLE      | waiting for i_run; config check
// LOAD_CTX  | accepting host CTX words, one RAM write per beat
// INIT_ST   | writing |0...0> into STATE RAM, one row per cycle
// START     | o_start pulse
// WAIT      | waiting for i_complete (first cycle ignored)
// RD_ADDR   | STATE RAM read request for row r
// RD_CAP    | capture read data
// RD_OUT    | present row r until accepted
// DONE      | o_done pulse
module qea_run_sequencer
  import qea_seq_pkg::*;
#(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  qea_run_sequencer_if.slave                 host,
  input  logic                               i_run,
  input  logic                               i_skip_ctx,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num,
  output logic                               o_ctx_en,
  output logic                               o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
  output logic [PE_NUM-1:0]                  o_state_ena,
  output logic [PE_NUM-1:0]                  o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dina,
  output logic                               o_start,
  input  logic                               i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dout,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err
`ifdef QEA_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]                        o_exec_cycles
`endif
);

  localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
  // amplitude of |0...0> = 1.0 + 0j, placed in the top PE slot of row 0
  localparam logic [ROW_W-1:0] ROW0_DINA =
    {DATA_WIDTH'(ONE_FP), {DATA_WIDTH{1'b0}}, {((PE_NUM-1)*STATE_DATA_WIDTH){1'b0}}};

  seq_state_t                         r_state;
  logic                               r_guard;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ins_num;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_k;
  logic [STATE_ADDR_WIDTH-1:0]        r_last_row;
  logic [STATE_ADDR_WIDTH-1:0]        r_row;
  logic                               r_ctx_ready;
  logic                               r_ctx_en;
  logic                               r_ctx_wea;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] r_ctx_data;
  logic [PE_NUM-1:0]                  r_state_ena;
  logic [PE_NUM-1:0]                  r_state_wea;
  logic [STATE_ADDR_WIDTH-1:0]        r_state_addra;
  logic [ROW_W-1:0]                   r_state_dina;
  logic                               r_start;
  logic                               r_rd_valid;
  logic [ROW_W-1:0]                   r_rd_data;
  logic                               r_rd_last;
  logic                               r_busy;
  logic                               r_done;
  logic                               r_err;

  int                                 w_qbit;
  logic                               w_qbit_ok;
  logic [STATE_ADDR_WIDTH-1:0]        w_last_row;
  logic                               w_cmpl_take;

  assign w_qbit      = int'(i_qbit_num);
  assign w_qbit_ok   = (w_qbit > PE_NUM_WIDTH) && ((w_qbit - PE_NUM_WIDTH) <= STATE_ADDR_WIDTH);
  assign w_last_row  = STATE_ADDR_WIDTH'(rows(w_qbit, PE_NUM_WIDTH) - 32'd1);
  assign w_cmpl_take = (r_state == S_WAIT) && !r_guard && i_complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_guard       <= 1'b0;
      r_ins_num     <= '0;
      r_k           <= '0;
      r_last_row    <= '0;
      r_row         <= '0;
      r_ctx_ready   <= 1'b0;
      r_ctx_en      <= 1'b0;
      r_ctx_wea     <= 1'b0;
      r_ctx_addr    <= '0;
      r_ctx_data    <= '0;
      r_state_ena   <= '0;
      r_state_wea   <= '0;
      r_state_addra <= '0;
      r_state_dina  <= '0;
      r_start       <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_rd_last     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_ctx_en    <= 1'b0;
      r_ctx_wea   <= 1'b0;
      r_state_ena <= '0;
      r_state_wea <= '0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            if (!w_qbit_ok) begin
              r_err <= 1'b1;
            end else begin
              r_err      <= 1'b0;
              r_busy     <= 1'b1;
              r_ins_num  <= i_ins_num;
              r_last_row <= w_last_row;
              r_k        <= '0;
              r_row      <= '0;
              if (i_skip_ctx || (i_ins_num == '0)) begin
                r_state <= S_INIT_ST;
              end else begin
                r_state     <= S_LOAD_CTX;
                r_ctx_ready <= 1'b1;
              end
            end
          end
        end
        S_LOAD_CTX: begin
          if (host.ctx_valid && r_ctx_ready) begin
            r_ctx_en   <= 1'b1;
            r_ctx_wea  <= 1'b1;
            r_ctx_addr <= r_k;
            r_ctx_data <= host.ctx_word;
            r_k        <= r_k + GATE_CONTEXT_ADDR_WIDTH'(1);
            if (r_k == r_ins_num - GATE_CONTEXT_ADDR_WIDTH'(1)) begin
              r_ctx_ready <= 1'b0;
              r_state     <= S_INIT_ST;
            end
          end
        end
        S_INIT_ST: begin
          r_state_ena   <= '1;
          r_state_wea   <= '1;
          r_state_addra <= r_row;
          r_state_dina  <= (r_row == '0) ? ROW0_DINA : '0;
          if (r_row == r_last_row) begin
            r_row   <= '0;
            r_start <= 1'b1;
            r_state <= S_START;
          end else begin
            r_row <= r_row + STATE_ADDR_WIDTH'(1);
          end
        end
        S_START: begin
          r_guard <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_guard <= 1'b0;
          if (w_cmpl_take) begin
            r_state_ena   <= '1;
            r_state_addra <= r_row;
            r_state       <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: r_state <= S_RD_CAP;
        S_RD_CAP: begin
          r_rd_data  <= i_state_dout;
          r_rd_valid <= 1'b1;
          r_rd_last  <= (r_row == r_last_row);
          r_state    <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (host.rd_ready) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            if (r_row == r_last_row) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_row         <= r_row + STATE_ADDR_WIDTH'(1);
              r_state_ena   <= '1;
              r_state_addra <= r_row + STATE_ADDR_WIDTH'(1);
              r_state       <= S_RD_ADDR;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef QEA_SEQ_CYCLE_CNT_EN
  logic [31:0] r_exec_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_exec_cycles <= '0;
    else if (r_state == S_START)
      r_exec_cycles <= '0;
    else if ((r_state == S_WAIT) && !w_cmpl_take && (r_exec_cycles != '1))
      r_exec_cycles <= r_exec_cycles + 32'd1;
  end

  assign o_exec_cycles = r_exec_cycles;
`endif

  assign host.ctx_ready = r_ctx_ready;
  assign host.rd_valid  = r_rd_valid;
  assign host.rd_data   = r_rd_data;
  assign host.rd_last   = r_rd_last;
  assign o_ctx_en       = r_ctx_en;
  assign o_ctx_wea      = r_ctx_wea;
  assign o_ctx_addr     = r_ctx_addr;
  assign o_ctx_data     = r_ctx_data;
  assign o_state_ena    = r_state_ena;
  assign o_state_wea    = r_state_wea;
  assign o_state_addra  = r_state_addra;
  assign o_state_dina   = r_state_dina;
  assign o_start        = r_start;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: tb/tb_qea_run_sequencer.sv
// Directed bench for qea_run_sequencer: reference model of expected CTX/init writes and readout rows,
// a per-cycle compare process, and literal per-run totals and latencies.
`timescale 1ns/1ps
module tb_qea_run_sequencer;

  localparam logic [255:0] ROW0 = {64'h40000000_00000000, 192'h0};

  typedef struct {
    logic [15:0] a;
    logic [63:0] d;
  } ctx_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_run = 1'b0;
  logic         i_skip_ctx = 1'b0;
  logic [5:0]   i_qbit_num = '0;
  logic [15:0]  i_ins_num = '0;
  logic         o_ctx_en, o_ctx_wea;
  logic [15:0]  o_ctx_addr;
  logic [63:0]  o_ctx_data;
  logic [3:0]   o_state_ena, o_state_wea;
  logic [15:0]  o_state_addra;
  logic [255:0] o_state_dina;
  logic         o_start;
  logic         i_complete = 1'b0;
  logic [255:0] i_state_dout = '0;
  logic         o_busy, o_done, o_err;
`ifdef QEA_SEQ_CYCLE_CNT_EN
  logic [31:0]  o_exec_cycles;
`endif

  qea_run_sequencer_if host_if();

  qea_run_sequencer dut (
    .clk(clk), .rst_n(rst_n), .host(host_if),
    .i_run(i_run), .i_skip_ctx(i_skip_ctx), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .o_start(o_start), .i_complete(i_complete),
    .i_state_dout(i_state_dout), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
`ifdef QEA_SEQ_CYCLE_CNT_EN
    , .o_exec_cycles(o_exec_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  ctx_t exp_ctx[$];
  int   m_rows = 0;
  int   n_ctx = 0, n_init = 0, n_rdaddr = 0, n_rd = 0, n_start = 0, n_done = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic to_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  function automatic logic [63:0] ctx_word(input int k);
    return {(32'(k) * 32'h0100_0193) ^ 32'hDEAD_BEEF, 32'(k) + 32'h1234_0000};
  endfunction

  function automatic logic [255:0] pat(input logic [15:0] a);
    logic [255:0] r;
    for (int l = 0; l < 4; l++)
      r[l*64 +: 64] = {32'(a) * 32'h9E37_79B9 + 32'(l), 32'hC0DE_0000 ^ 32'(a) ^ (32'(l) << 20)};
    return r;
  endfunction

  function automatic logic any_out();
    return |{o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data, o_state_ena, o_state_wea, o_state_addra,
             o_state_dina, o_start, host_if.ctx_ready, host_if.rd_valid, host_if.rd_data,
             host_if.rd_last, o_busy, o_done, o_err
`ifdef QEA_SEQ_CYCLE_CNT_EN
             , o_exec_cycles
`endif
             };
  endfunction

  // QEA STATE RAM read model: one-cycle latency
  initial begin
    logic        hit;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      hit = (o_state_ena != 0) && (o_state_wea == 0);
      a = o_state_addra;
      @(posedge clk);
      #1;
      if (hit) i_state_dout = pat(a);
    end
  end

  initial begin
    host_if.rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      host_if.rd_ready = 1'($urandom_range(0, 1));
    end
  end

  // Per-cycle compare against the model
  initial begin
    ctx_t         e;
    logic         stalled = 1'b0;
    logic [255:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      if (o_ctx_en) begin
        n_ctx++;
        if (exp_ctx.size() == 0) to_fail("ctx_unexpected_write");
        else begin
          e = exp_ctx.pop_front();
          chk("ctx_addr", o_ctx_addr, e.a);
          chk("ctx_data", o_ctx_data, e.d);
          chk("ctx_wea", o_ctx_wea, 1);
        end
      end
      if (o_state_ena != 0) begin
        chk("st_ena_all", o_state_ena, 4'hF);
        if (o_state_wea != 0) begin
          chk("init_wea_all", o_state_wea, 4'hF);
          if (n_init >= m_rows) to_fail("init_extra_write");
          else begin
            chk("init_addr", o_state_addra, n_init);
            chk("init_dina", o_state_dina, (n_init == 0) ? ROW0 : 256'h0);
          end
          n_init++;
        end else begin
          chk("rd_addr", o_state_addra, n_rdaddr);
          n_rdaddr++;
        end
      end
      if (o_start) n_start++;
      if (o_done) n_done++;
      if (host_if.rd_valid) begin
        if (stalled) chk("rd_stable", host_if.rd_data, held);
        if (host_if.rd_ready) begin
          chk("rd_data", host_if.rd_data, pat(16'(n_rd)));
          chk("rd_last", host_if.rd_last, (n_rd == m_rows - 1));
          n_rd++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = host_if.rd_data;
        end
      end
    end
  end

  task automatic pulse_run(input int q, input int n, input bit skip);
    @(posedge clk);
    #1;
    i_run = 1'b1; i_qbit_num = 6'(q); i_ins_num = 16'(n); i_skip_ctx = skip;
    @(posedge clk);
    #1;
    i_run = 1'b0; i_skip_ctx = 1'b0;
  endtask

  // lat_l: negedge count after the start pulse at which i_complete rises (0 = during START itself)
  task automatic run_seq(input int q, input int n, input bit skip, input int lat_l, input int abort_at,
                         input int e_ctx, input int e_rows, input int e_lat);
    int budget;
    int lat;
    exp_ctx.delete();
    m_rows = 1 << (q - 2);
    n_ctx = 0; n_init = 0; n_rdaddr = 0; n_rd = 0; n_start = 0; n_done = 0;
    if (!skip)
      for (int k = 0; k < n; k++) exp_ctx.push_back('{a: 16'(k), d: ctx_word(k)});
    pulse_run(q, n, skip);
    @(negedge clk);
    chk("err_cleared", o_err, 0);
    chk("busy_on_run", o_busy, 1);
    @(posedge clk);
    #1;
    if (!skip) begin
      for (int i = 0; i < n; i++) begin
        if (i == abort_at) begin
          host_if.ctx_valid = 1'b0;
          @(negedge clk);
          #1;
          rst_n = 1'b0;
          #1;
          chk("rst_outputs_zero", any_out(), 0);
          chk("ctx_before_abort", n_ctx, e_ctx);
          repeat (2) @(posedge clk);
          #1;
          rst_n = 1'b1;
          return;
        end
        if ($urandom_range(0, 2) != 0) begin
          host_if.ctx_valid = 1'b0;
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
          end
        end
        host_if.ctx_valid = 1'b1;
        host_if.ctx_word = ctx_word(i);
        budget = 0;
        forever begin
          @(negedge clk);
          if (host_if.ctx_ready) break;
          if (++budget > 50) begin
            to_fail("ctx_ready_timeout");
            host_if.ctx_valid = 1'b0;
            return;
          end
        end
        @(posedge clk);
        #1;
      end
      host_if.ctx_valid = 1'b0;
    end
    budget = 0;
    forever begin
      @(negedge clk);
      if (o_start) break;
      if (++budget > 500) begin
        to_fail("start_timeout");
        return;
      end
    end
    if (lat_l == 0) i_complete = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == lat_l) i_complete = 1'b1;
      if (lat_l == 20 && lat == 5) begin
        i_run = 1'b1; i_qbit_num = 6'd2;
      end
      if (lat_l == 20 && lat == 6) i_run = 1'b0;
      if ((o_state_ena != 0) && (o_state_wea == 0)) break;
      if (lat > 300) begin
        to_fail("complete_timeout");
        i_complete = 1'b0;
        return;
      end
    end
    i_run = 1'b0;
    i_complete = 1'b0;
    chk("complete_latency", lat, e_lat);
`ifdef QEA_SEQ_CYCLE_CNT_EN
    chk("exec_cycles", o_exec_cycles, lat - 2);
`endif
    budget = 0;
    forever begin
      @(negedge clk);
      if (o_done) break;
      if (++budget > 3000) begin
        to_fail("done_timeout");
        return;
      end
    end
    @(negedge clk);
    #1;
    chk("n_ctx_writes", n_ctx, e_ctx);
    chk("n_init_writes", n_init, e_rows);
    chk("n_rd_rows", n_rd, e_rows);
    chk("n_rd_reads", n_rdaddr, e_rows);
    chk("n_start_cycles", n_start, 1);
    chk("n_done_cycles", n_done, 1);
    chk("busy_after_done", o_busy, 0);
    chk("err_after_run", o_err, 0);
  endtask

  initial begin
    host_if.ctx_valid = 1'b0;
    host_if.ctx_word = '0;
    #1;
    chk("reset_outputs_zero", any_out(), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    pulse_run(2, 0, 0);
    @(negedge clk);
    chk("err_qbit2", o_err, 1);
    chk("busy_qbit2", o_busy, 0);
    pulse_run(19, 0, 0);
    @(negedge clk);
    chk("err_qbit19", o_err, 1);
    chk("busy_qbit19", o_busy, 0);

    // qbit 8: 64 rows; i_complete forced during START -> taken after guard cycle
    run_seq(8, 563, 0, 0, -1, 563, 64, 3);
    // qbit 3: 2 rows, ins_num 0 skips LOAD_CTX; i_run with bad qbit while busy is ignored
    run_seq(3, 0, 0, 20, -1, 0, 2, 21);
    // reset mid-load after 100 beats
    run_seq(8, 563, 0, 7, 100, 100, 64, 8);
    // reuse CTX
    run_seq(8, 563, 1, 7, -1, 0, 64, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
